// File: rtl/gray_pkg.sv
// Shared constants for the Gray counter and its downstream gray_to_bin stage.
package gray_pkg;
  localparam int GRAY_WIDTH_DEF = 4;
  localparam int GRAY_RST_VAL   = 0;

  // Reflected binary encoding, usable by any WIDTH up to 16.
  function automatic logic [15:0] bin2gray16(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder, WIDTH-parameterised.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder; consumes the gray_counter output stream.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end
endmodule

// File: rtl/gray_counter.sv
// Loadable Gray/binary counter with wrap pulse and update strobe.
// Define GRAY_CNT_UPDOWN_EN to honour up_dn; otherwise it counts up only.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             upd
);
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(GRAY_RST_VAL);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             dir_up;
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;

`ifdef GRAY_CNT_UPDOWN_EN
  assign dir_up = up_dn;
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
  assign dir_up       = 1'b1;
`endif

  assign step = en && !load;
  assign wrap = step && (dir_up ? (bin == ALL_ONES) : (bin == '0));

  always_comb begin
    bin_nxt = bin;
    if (load)      bin_nxt = load_bin;
    else if (en)   bin_nxt = dir_up ? bin + 1'b1 : bin - 1'b1;
  end

  bin_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= RST_VAL;
      gray <= RST_VAL ^ (RST_VAL >> 1);
      tc   <= 1'b0;
      upd  <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
      tc   <= wrap;
      upd  <= (gray_nxt != gray);
    end
  end
endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (WIDTH=4) plus gray_to_bin.
module tb_gray_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] gray, bin, conv_bin;
  logic         tc, upd;

  int errors = 0;
  int checks = 0;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray(gray), .bin(bin), .tc(tc), .upd(upd)
  );

  gray_to_bin #(.WIDTH(W)) u_g2b (.gray(gray), .bin(conv_bin));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; load = 1'b0; up_dn = 1'b1;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (gray !== 4'b0000) begin errors++; $display("FAIL reset_gray got=%b exp=0000", gray); end
    checks++; if (bin !== 4'b0000) begin errors++; $display("FAIL reset_bin got=%b exp=0000", bin); end
    checks++; if (tc !== 1'b0 || upd !== 1'b0) begin errors++; $display("FAIL reset_flags got tc=%b upd=%b exp 0 0", tc, upd); end
    rst_n = 1'b1;
    tick();
    checks++; if (gray !== 4'b0000 || upd !== 1'b0) begin errors++; $display("FAIL idle_hold got gray=%b upd=%b exp 0000 0", gray, upd); end
  endtask

  task automatic test_up_sweep();
    logic [W-1:0] exp_g [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    logic [W-1:0] prev;
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prev = gray;
      tick();
      checks++; if (gray !== exp_g[i]) begin errors++; $display("FAIL up_gray[%0d] got=%b exp=%b", i, gray, exp_g[i]); end
      checks++; if (bin !== 4'((i + 1) % 16)) begin errors++; $display("FAIL up_bin[%0d] got=%b exp=%0d", i, bin, (i + 1) % 16); end
      checks++; if (tc !== (i == 15)) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc, i == 15); end
      checks++; if ($countones(gray ^ prev) != 1) begin errors++; $display("FAIL up_onebit[%0d] prev=%b now=%b", i, prev, gray); end
      checks++; if (upd !== 1'b1) begin errors++; $display("FAIL up_upd[%0d] got=%b exp=1", i, upd); end
      checks++; if (conv_bin !== 4'((i + 1) % 16)) begin errors++; $display("FAIL g2b[%0d] got=%b exp=%0d", i, conv_bin, (i + 1) % 16); end
    end
    en = 1'b0;
    tick();
    checks++; if (tc !== 1'b0 || upd !== 1'b0 || gray !== 4'b0000) begin errors++; $display("FAIL up_stop got tc=%b upd=%b gray=%b exp 0 0 0000", tc, upd, gray); end
  endtask

  task automatic test_direction();
    do_reset();
    en = 1'b1; up_dn = 1'b0;
`ifdef GRAY_CNT_UPDOWN_EN
    tick();
    checks++; if (gray !== 4'b1000 || bin !== 4'b1111) begin errors++; $display("FAIL dn_wrap got gray=%b bin=%b exp 1000 1111", gray, bin); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_wrap_tc got=%b exp=1", tc); end
    tick();
    checks++; if (gray !== 4'b1001 || bin !== 4'b1110) begin errors++; $display("FAIL dn_step got gray=%b bin=%b exp 1001 1110", gray, bin); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_step_tc got=%b exp=0", tc); end
`else
    tick();
    checks++; if (gray !== 4'b0001 || tc !== 1'b0) begin errors++; $display("FAIL ign_dir0 got gray=%b tc=%b exp 0001 0", gray, tc); end
    tick();
    checks++; if (gray !== 4'b0011) begin errors++; $display("FAIL ign_dir1 got=%b exp=0011", gray); end
    tick();
    checks++; if (gray !== 4'b0010 || bin !== 4'b0011) begin errors++; $display("FAIL ign_dir2 got gray=%b bin=%b exp 0010 0011", gray, bin); end
`endif
    en = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_bin = 4'b0101; en = 1'b1;
    tick();
    checks++; if (bin !== 4'b0101 || gray !== 4'b0111) begin errors++; $display("FAIL load_val got bin=%b gray=%b exp 0101 0111", bin, gray); end
    checks++; if (tc !== 1'b0 || upd !== 1'b1) begin errors++; $display("FAIL load_flags got tc=%b upd=%b exp 0 1", tc, upd); end
    load = 1'b0; en = 1'b0;
    tick();
    checks++; if (bin !== 4'b0101 || gray !== 4'b0111 || upd !== 1'b0) begin errors++; $display("FAIL load_hold got bin=%b gray=%b upd=%b exp 0101 0111 0", bin, gray, upd); end
    load = 1'b1;
    tick();
    checks++; if (upd !== 1'b0 || bin !== 4'b0101) begin errors++; $display("FAIL load_same got upd=%b bin=%b exp 0 0101", upd, bin); end
    load_bin = 4'b1111;
    tick();
    checks++; if (bin !== 4'b1111 || gray !== 4'b1000 || tc !== 1'b0 || upd !== 1'b1) begin errors++; $display("FAIL load_ones got bin=%b gray=%b tc=%b upd=%b exp 1111 1000 0 1", bin, gray, tc, upd); end
    load_bin = 4'b0000; en = 1'b1;
    tick();
    checks++; if (bin !== 4'b0000 || tc !== 1'b0) begin errors++; $display("FAIL load_zero_nowrap got bin=%b tc=%b exp 0000 0", bin, tc); end
    load = 1'b0;
    tick();
    checks++; if (bin !== 4'b0001 || gray !== 4'b0001) begin errors++; $display("FAIL load_then_step got bin=%b gray=%b exp 0001 0001", bin, gray); end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    repeat (6) tick();
    checks++; if (bin !== 4'b0110 || gray !== 4'b0101) begin errors++; $display("FAIL pre_rst got bin=%b gray=%b exp 0110 0101", bin, gray); end
    load = 1'b1; load_bin = 4'b1001;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (gray !== 4'b0000 || bin !== 4'b0000 || tc !== 1'b0 || upd !== 1'b0) begin errors++; $display("FAIL async_rst got gray=%b bin=%b tc=%b upd=%b exp 0000 0000 0 0", gray, bin, tc, upd); end
    tick();
    checks++; if (bin !== 4'b0000) begin errors++; $display("FAIL rst_discard got bin=%b exp 0000", bin); end
    load = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    checks++; if (gray !== 4'b0001 || bin !== 4'b0001) begin errors++; $display("FAIL rst_resume got gray=%b bin=%b exp 0001 0001", gray, bin); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_direction();
    test_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL provide port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port: en  input  1  count enable, sampled on the rising edge of clk.
REQ-005 SHALL provide port: up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-006 SHALL provide port: load  input  1  synchronous load strobe.
REQ-007 SHALL provide port: load_bin  input  WIDTH  binary value to load.
REQ-008 SHALL provide port: gray  output  WIDTH  registered Gray-coded count; this is the stream consumed by the downstream gray_to_bin stage.
REQ-009 SHALL provide port: bin  output  WIDTH  registered binary count; gray always equals bin ^ (bin >> 1).
REQ-010 SHALL provide port: tc  output  1  registered terminal-count (wrap) pulse.
REQ-011 SHALL provide port: upd  output  1  registered one-cycle strobe, high when gray changed on the last edge.

Function
REQ-012 SHALL hold an internal binary state register; gray and bin SHALL be driven from registers, with no combinational path from any input to any output.
REQ-013 Priority per clock edge SHALL be load > en > hold.
REQ-014 load=1: bin SHALL take load_bin and gray SHALL take its Gray encoding on the same edge; en and up_dn are ignored on that edge.
REQ-015 load=0, en=1, up_dn=1: bin SHALL advance by 1 modulo 2^WIDTH, with gray updated on the same edge.
REQ-016 load=0, en=1, up_dn=0: bin SHALL decrement by 1 modulo 2^WIDTH.
REQ-017 load=0, en=0: all state SHALL hold; tc=0 and upd=0 on the following cycle.
REQ-018 Latency SHALL be one clock: the edge that samples en=1 or load=1 presents the new gray and bin values.
REQ-019 Every en-driven step SHALL change exactly one gray bit, including wrap-around.
REQ-020 tc SHALL be 1 for exactly the one cycle after an en-driven wrap: up from all-ones to 0, or down from 0 to all-ones.
REQ-021 A load SHALL never assert tc, even when load_bin is 0 or all-ones.
REQ-022 upd SHALL be 1 for the cycle after any edge on which gray changed value; a load of the current value SHALL give upd=0.
REQ-023 When en is held high continuously, the counter SHALL step on every edge with no bubbles.

Reset
REQ-024 rst_n low SHALL immediately force gray=0, bin=0, tc=0 and upd=0, independent of clk.
REQ-025 Reset asserted mid-count SHALL discard any pending load or step.
REQ-026 After rst_n deasserts, the first rising clk edge SHALL act normally on en and load.

Configuration
REQ-027 Macro GRAY_CNT_UPDOWN_EN SHALL control the direction feature.
REQ-028 With GRAY_CNT_UPDOWN_EN defined, up_dn SHALL select the direction as in REQ-015 and REQ-016.
REQ-029 Without GRAY_CNT_UPDOWN_EN, the up_dn port SHALL remain present but be ignored, and the counter SHALL count up only; all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package gray_pkg SHALL hold GRAY_WIDTH_DEF (4) and GRAY_RST_VAL (0); this block and gray_to_bin SHALL both use them.
REQ-031 The Gray encoding SHALL be a combinational sub-module bin_to_gray (WIDTH-parameterised), instantiated once on the next-state binary value before the gray register.

Verification (WIDTH=4)
REQ-032 Reset, then en=1, up_dn=1 for 16 cycles -> gray 0001,0011,0010,0110,0111,0101,0100,1100,...,1000,0000; tc=1 only after the 1000->0000 step; exactly one bit changes per step.
REQ-033 From reset, en=1, up_dn=0 for one cycle -> gray=1000, bin=1111, tc=1; the next down step gives gray=1001, tc=0.
REQ-034 load=1, load_bin=0101 with en=1 on the same edge -> bin=0101, gray=0111, tc=0, upd=1; en=0 afterwards -> values hold, upd=0.
REQ-035 Count to bin=0110 (gray=0101), then pull rst_n low between clock edges -> gray=0000 and bin=0000 immediately; release -> counting resumes from 0001.
REQ-036 Build without GRAY_CNT_UPDOWN_EN, drive up_dn=0 and en=1 for 3 cycles -> gray sequence 0001,0011,0010.
REQ-037 Connect gray to gray_to_bin and run a full up sweep -> the converter output equals bin on every cycle.
